// File: rtl/target_sprite_gen.sv
// target_sprite_gen: draws/erases a SIZE x SIZE ROM sprite at LFSR-chosen spots and scores cursor clicks.
// Define TARGET_HOVER_DIM_EN to darken the sprite while the cursor hovers near its centre.
module target_sprite_gen #(
    parameter int          SIZE        = 32,
    parameter int          SCREEN_W    = 160,
    parameter int          SCREEN_H    = 120,
    parameter int          HOLD_FRAMES = 60,
    parameter int          SCORE_W     = 6,
    parameter int          POINTS      = 1,
    parameter logic [15:0] LFSR_SEED   = 16'hFFFF,
    localparam int         AW          = $clog2(SIZE)
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 active,
    output logic                 done,
    output logic                 clear,
    output logic                 writeEn,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [23:0]          colour,
    output logic [2*AW-1:0]      rom_addr,
    input  logic [23:0]          rom_data,
    input  logic [7:0]           x_c,
    input  logic [6:0]           y_c,
    input  logic [2:0]           button,
    output logic [SCORE_W-1:0]   score
);
    localparam int N = SIZE * SIZE;
    localparam int FW = $clog2(HOLD_FRAMES + 1);
    localparam logic [8:0] XMAX = 9'(SCREEN_W - SIZE);
    localparam logic [8:0] YMAX = 9'(SCREEN_H - SIZE);
    localparam logic [SCORE_W:0] SMAX = {1'b0, {SCORE_W{1'b1}}};

    typedef enum logic [2:0] {LOAD, DELAY, PLOT, WAIT, ERASE, UPDATE} state_t;
    typedef enum logic [1:0] {IDLE, PRESSED, RELEASE} hit_t;

    state_t              state_q, state_d;
    hit_t                hit_state_q, hit_state_d;
    logic [2*AW-1:0]     cnt_q, cnt_d;
    logic [7:0]          x0_q, x0_d;
    logic [6:0]          y0_q, y0_d;
    logic [FW-1:0]       frame_q, frame_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic                pending_q, pending_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [23:0]         pix;
    logic                hit, in_box, last, reloc;
    logic [8:0]          x0_9, y0_9, xc_9, yc_9, cx_w, cy_w;
    logic [SCORE_W:0]    sum;
    logic                unused;

    assign unused = ^button[2:1];
    assign last   = cnt_q == (2*AW)'(N - 1);
    assign x0_9   = {1'b0, x0_q};
    assign y0_9   = {2'b0, y0_q};
    assign xc_9   = {1'b0, x_c};
    assign yc_9   = {2'b0, y_c};
    assign in_box = xc_9 >= x0_9 && xc_9 <= x0_9 + 9'(SIZE - 1) &&
                    yc_9 >= y0_9 && yc_9 <= y0_9 + 9'(SIZE - 1);
    assign hit    = hit_state_q == RELEASE && active && in_box;
    assign sum    = {1'b0, score_q} + (SCORE_W + 1)'(POINTS);
    assign reloc  = frame_q <= FW'(1) || pending_q || hit;
    assign cx_w   = {1'b0, lfsr_q[15:8]} > XMAX ? {1'b0, lfsr_q[15:8]} - XMAX - 9'd1 : {1'b0, lfsr_q[15:8]};
    assign cy_w   = {2'b0, lfsr_q[6:0]} > YMAX ? {2'b0, lfsr_q[6:0]} - YMAX - 9'd1 : {2'b0, lfsr_q[6:0]};

    assign writeEn  = state_q == PLOT || state_q == ERASE;
    assign done     = state_q == WAIT;
    assign clear    = state_q == WAIT || state_q == ERASE;
    assign x        = x0_q + 8'(cnt_q[AW-1:0]);
    assign y        = y0_q + 7'(cnt_q[2*AW-1:AW]);
    assign rom_addr = state_q == PLOT ? cnt_q + 1'b1 : '0;
    assign colour   = state_q == PLOT ? pix : 24'hFFFFFF;
    assign score    = score_q;

`ifdef TARGET_HOVER_DIM_EN
    localparam logic signed [10:0] HALF = 11'(SIZE / 2 - 1);
    localparam logic signed [22:0] R2   = 23'((SIZE / 2 - 1) * (SIZE / 2 - 1));
    logic [23:0]        offset_q, offset_d;
    logic signed [10:0] dx, dy;
    always_comb begin
        dx = $signed({3'b0, x_c}) - $signed({3'b0, x0_q}) - HALF;
        dy = $signed({4'b0, y_c}) - $signed({4'b0, y0_q}) - HALF;
        offset_d = (23'(dx) * 23'(dx) + 23'(dy) * 23'(dy) <= R2) ? 24'h202020 : 24'h0;
        pix[23:16] = rom_data[23:16] > offset_q[23:16] ? rom_data[23:16] - offset_q[23:16] : 8'h00;
        pix[15:8]  = rom_data[15:8]  > offset_q[15:8]  ? rom_data[15:8]  - offset_q[15:8]  : 8'h00;
        pix[7:0]   = rom_data[7:0]   > offset_q[7:0]   ? rom_data[7:0]   - offset_q[7:0]   : 8'h00;
    end
    always_ff @(posedge CLOCK_50)
        offset_q <= reset ? 24'h0 : offset_d;
`else
    assign pix = rom_data;
`endif

    always_comb begin
        hit_state_d = hit_state_q == IDLE    ? (button[0] ? PRESSED : IDLE) :
                      hit_state_q == PRESSED ? (button[0] ? PRESSED : RELEASE) : IDLE;
        score_d     = hit ? (sum > SMAX ? SMAX[SCORE_W-1:0] : sum[SCORE_W-1:0]) : score_q;
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        pending_d   = pending_q | hit;
        state_d     = state_q;
        cnt_d       = cnt_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        frame_d     = frame_q;
        case (state_q)
            LOAD:   state_d = active ? DELAY : LOAD;
            DELAY:  begin
                state_d = PLOT;
                cnt_d   = '0;
            end
            PLOT:   begin
                cnt_d   = cnt_q + 1'b1;
                state_d = last ? WAIT : PLOT;
            end
            WAIT:   begin
                state_d = start ? ERASE : WAIT;
                cnt_d   = '0;
            end
            ERASE:  begin
                cnt_d   = cnt_q + 1'b1;
                state_d = last ? UPDATE : ERASE;
            end
            UPDATE: begin
                state_d = LOAD;
                frame_d = reloc ? FW'(HOLD_FRAMES) : frame_q - 1'b1;
                if (reloc) begin
                    x0_d      = cx_w > XMAX ? XMAX[7:0] : cx_w[7:0];
                    y0_d      = cy_w > YMAX ? YMAX[6:0] : cy_w[6:0];
                    pending_d = 1'b0;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= LOAD;
            hit_state_q <= IDLE;
            cnt_q       <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            frame_q     <= FW'(HOLD_FRAMES);
            lfsr_q      <= LFSR_SEED;
            pending_q   <= 1'b0;
            score_q     <= '0;
        end else begin
            state_q     <= state_d;
            hit_state_q <= hit_state_d;
            cnt_q       <= cnt_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            frame_q     <= frame_d;
            lfsr_q      <= lfsr_d;
            pending_q   <= pending_d;
            score_q     <= score_d;
        end
    end
endmodule

// File: tb/tb_target_sprite_gen.sv
// tb_target_sprite_gen: random-ROM scoreboard bench for target_sprite_gen with a reference model of origin, LFSR and score.
module tb_target_sprite_gen;
    localparam int SZ = 32;
    localparam int N = SZ * SZ;
    localparam int H = 4;

    typedef struct {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [23:0] c;
    } pix_t;

    logic        clk = 0;
    logic        reset = 1, start = 0, active = 0;
    logic        done, clear, writeEn;
    logic [7:0]  x, x_c = 0;
    logic [6:0]  y, y_c = 0;
    logic [23:0] colour, rom_data;
    logic [9:0]  rom_addr;
    logic [2:0]  button = 0;
    logic [5:0]  score;

    logic [23:0] rom [0:N-1];
    pix_t        exp_q[$];
    int          n_cmp = 0, n_bad = 0;
    int          m_x0 = 0, m_y0 = 0, m_fc = H, m_score = 0;
    bit          m_pend = 0;
    logic [15:0] m_lfsr;

    target_sprite_gen #(.HOLD_FRAMES(H)) dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .active(active),
        .done(done), .clear(clear), .writeEn(writeEn), .x(x), .y(y),
        .colour(colour), .rom_addr(rom_addr), .rom_data(rom_data),
        .x_c(x_c), .y_c(y_c), .button(button), .score(score)
    );

    always #10 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    always @(posedge clk)
        m_lfsr <= reset ? 16'hFFFF : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

    always @(negedge clk) begin
        if (!reset && writeEn === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pixel_unexpected: got write at (%0d,%0d) colour %06h, want no write", x, y, colour);
            end else begin
                pix_t e;
                e = exp_q.pop_front();
                n_cmp++;
                if (x !== e.x || y !== e.y || colour !== e.c) begin
                    n_bad++;
                    $display("FAIL pixel: got (%0d,%0d) %06h, want (%0d,%0d) %06h", x, y, colour, e.x, e.y, e.c);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    task automatic abort(input string name);
        n_bad++;
        $display("FAIL %s: timed out", name);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    endtask

    function automatic int fold(input int v, input int mx);
        int r;
        r = v > mx ? v - mx - 1 : v;
        return r > mx ? mx : r;
    endfunction

    task automatic push_frame();
        for (int k = 0; k < N; k++) exp_q.push_back('{8'(m_x0 + k % SZ), 7'(m_y0 + k / SZ), rom[k]});
        for (int k = 0; k < N; k++) exp_q.push_back('{8'(m_x0 + k % SZ), 7'(m_y0 + k / SZ), 24'hFFFFFF});
    endtask

    task automatic click(input int cx, input int cy);
        bit hit;
        x_c = 8'(cx);
        y_c = 7'(cy);
        hit = active && int'(x_c) >= m_x0 && int'(x_c) <= m_x0 + SZ - 1 &&
              int'(y_c) >= m_y0 && int'(y_c) <= m_y0 + SZ - 1;
        button = 3'b001;
        repeat (3) @(negedge clk);
        button = 3'b000;
        @(negedge clk);
        check("score_before_release", score, m_score);
        if (hit) begin
            m_score = m_score < 63 ? m_score + 1 : 63;
            m_pend = 1;
        end
        @(negedge clk);
        check("score_after_release", score, m_score);
        @(negedge clk);
    endtask

    task automatic run_frame(input int kind);
        int i;
        push_frame();
        for (i = 0; i < 3000 && done !== 1'b1; i++) @(negedge clk);
        if (done !== 1'b1) abort("wait_done");
        check("wait_clear", clear, 1'b1);
        check("wait_queue_drained", exp_q.size(), N);
        case (kind)
            1: begin
                click(m_x0 + 5, m_y0 + 5);
                click(m_x0 + SZ, m_y0);
                click(m_x0 + SZ - 1, m_y0 + SZ - 1);
                click(m_x0 - 1, m_y0);
                active = 0;
                click(m_x0 + 5, m_y0 + 5);
                active = 1;
            end
            2: for (int c = 0; c < 70; c++) click(m_x0 + $urandom_range(0, SZ - 1), m_y0 + $urandom_range(0, SZ - 1));
            3: for (int c = 0; c < 5; c++)
                if ($urandom_range(0, 1) == 1) click(m_x0 + $urandom_range(0, SZ - 1), m_y0 + $urandom_range(0, SZ - 1));
                else click($urandom_range(0, 159), $urandom_range(0, 119));
            default: ;
        endcase
        start = 1;
        @(negedge clk);
        start = 0;
        for (i = 0; i < N + 10 && writeEn === 1'b1; i++) @(negedge clk);
        if (writeEn !== 1'b0) abort("wait_erase_end");
        check("update_clear", clear, 1'b0);
        check("erase_queue_drained", exp_q.size(), 0);
        m_fc--;
        if (m_fc == 0 || m_pend) begin
            m_x0 = fold(int'(m_lfsr[15:8]), 160 - SZ);
            m_y0 = fold(int'(m_lfsr[6:0]), 120 - SZ);
            m_fc = H;
            m_pend = 0;
        end
    endtask

    initial begin
        #2_000_000;
        abort("watchdog");
    end

    initial begin
        int cnt;
        for (int k = 0; k < N; k++) rom[k] = 24'($urandom);
        repeat (3) @(negedge clk);
        check("reset_writeEn", writeEn, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_clear", clear, 1'b0);
        check("reset_colour", colour, 24'hFFFFFF);
        check("reset_score", score, 0);
        reset = 0;
        repeat (4) @(negedge clk);
        check("load_holds_writeEn", writeEn, 1'b0);
        check("load_holds_done", done, 1'b0);
        active = 1;
        for (int f = 0; f < H; f++) run_frame(0);
        run_frame(1);
        run_frame(0);
        run_frame(2);
        for (int f = 0; f < 3; f++) run_frame(3);
        push_frame();
        cnt = 0;
        for (int i = 0; i < 3000 && cnt < 500; i++) begin
            @(negedge clk);
            if (writeEn === 1'b1) cnt++;
        end
        if (cnt < 500) abort("wait_pixel_500");
        reset = 1;
        @(negedge clk);
        check("midplot_reset_writeEn", writeEn, 1'b0);
        check("midplot_reset_done", done, 1'b0);
        check("midplot_reset_clear", clear, 1'b0);
        check("midplot_reset_score", score, 0);
        exp_q.delete();
        m_x0 = 0;
        m_y0 = 0;
        m_fc = H;
        m_pend = 0;
        m_score = 0;
        reset = 0;
        run_frame(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
